// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-RAM port arbiter.
// Imported by the arbiter top and its sub-modules.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DSP
  } owner_t;

  localparam int unsigned RAM_BASE_DEF = 31000;
  localparam int unsigned SIZE_RAM_DEF = 30030;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between CPU, DSP reader, arbiter and RAM.
// slave = arbiter view, master = environment view.
interface dmem_port_arbiter_if #(
  parameter int S = 32,
  parameter int V = 192
);

  logic         cpu_req;
  logic         cpu_we;
  logic         cpu_vec;
  logic [S-1:0] cpu_addr;
  logic [V-1:0] cpu_wd;
  logic         cpu_ack;
  logic [V-1:0] cpu_rd;
  logic         cpu_err;

  logic         dsp_req;
  logic [S-1:0] dsp_addr;
  logic         dsp_ack;
  logic [V-1:0] dsp_rd;
  logic         dsp_err;

  logic         mem_we;
  logic         mem_vec;
  logic [S-1:0] mem_addr;
  logic [V-1:0] mem_wd;
  logic [V-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_vec,
    input  cpu_addr, cpu_wd,
    output cpu_ack, cpu_rd, cpu_err,
    input  dsp_req, dsp_addr,
    output dsp_ack, dsp_rd, dsp_err,
    output mem_we, mem_vec,
    output mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_vec,
    output cpu_addr, cpu_wd,
    input  cpu_ack, cpu_rd, cpu_err,
    output dsp_req, dsp_addr,
    input  dsp_ack, dsp_rd, dsp_err,
    input  mem_we, mem_vec,
    input  mem_addr, mem_wd,
    output mem_rd
  );

endinterface

// File: rtl/starve_counter.sv
// Saturating wait counter; sat flags that DSP has waited
// long enough to override CPU priority.
module starve_counter #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  assign o_sat = (r_cnt == W'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-RAM port between CPU and a read-only DSP
// stream: CPU priority with a starvation override for DSP.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          S        = 32,
  parameter int          V        = 192,
  parameter int unsigned RAM_BASE = RAM_BASE_DEF,
  parameter int unsigned SIZE_RAM = SIZE_RAM_DEF,
  parameter int          MAX_WAIT = 8
) (
  input logic               clk,
  input logic               rst,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [S-1:0] LO = S'(RAM_BASE);
  localparam logic [S-1:0] HI = S'(RAM_BASE + SIZE_RAM);

  state_t r_state, w_state_n;
  owner_t r_owner, w_owner_n;

  logic         r_we, w_we_n;
  logic         r_oor, w_oor_n;
  logic         r_mem_we, w_mem_we_n;
  logic         r_mem_vec, w_mem_vec_n;
  logic [S-1:0] r_mem_addr, w_mem_addr_n;
  logic [V-1:0] r_mem_wd, w_mem_wd_n;
  logic         r_cpu_ack, w_cpu_ack_n;
  logic         r_cpu_err, w_cpu_err_n;
  logic [V-1:0] r_cpu_rd, w_cpu_rd_n;
  logic         r_dsp_ack, w_dsp_ack_n;
  logic         r_dsp_err, w_dsp_err_n;
  logic [V-1:0] r_dsp_rd, w_dsp_rd_n;

  logic         w_any;
  logic         w_sat;
  logic         w_pick_dsp;
  logic         w_dsp_grant;
  logic         w_dsp_busy;
  logic         w_inc;
  logic         w_clr;
  logic [S-1:0] w_addr;
  logic         w_inr;
  logic [V-1:0] w_rd_cap;

  assign w_any       = bus.cpu_req | bus.dsp_req;
  assign w_pick_dsp  = bus.dsp_req & (w_sat | ~bus.cpu_req);
  assign w_dsp_grant = (r_state == IDLE) & w_pick_dsp;
  assign w_dsp_busy  = (r_state != IDLE) & (r_owner == OWN_DSP);
  assign w_inc       = bus.dsp_req & ~w_dsp_busy & ~w_dsp_grant;
  assign w_clr       = ~bus.dsp_req | w_dsp_grant;

  assign w_addr = w_pick_dsp ? bus.dsp_addr : bus.cpu_addr;
  assign w_inr  = (w_addr >= LO) && (w_addr < HI);

  // Writes and out-of-range accesses return zero read data
  assign w_rd_cap = (r_oor | r_we) ? '0 : bus.mem_rd;

  starve_counter #(
    .MAX (MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_n = ACCESS;
      ACCESS:  w_state_n = DONE;
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_owner_n    = r_owner;
    w_we_n       = r_we;
    w_oor_n      = r_oor;
    w_mem_we_n   = 1'b0;
    w_mem_vec_n  = r_mem_vec;
    w_mem_addr_n = r_mem_addr;
    w_mem_wd_n   = r_mem_wd;
    w_cpu_ack_n  = 1'b0;
    w_cpu_err_n  = 1'b0;
    w_cpu_rd_n   = r_cpu_rd;
    w_dsp_ack_n  = 1'b0;
    w_dsp_err_n  = 1'b0;
    w_dsp_rd_n   = r_dsp_rd;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_n    = w_pick_dsp ? OWN_DSP : OWN_CPU;
          w_we_n       = ~w_pick_dsp & bus.cpu_we;
          w_oor_n      = ~w_inr;
          w_mem_we_n   = w_we_n & w_inr;
          w_mem_vec_n  = w_pick_dsp | bus.cpu_vec;
          w_mem_addr_n = w_addr - LO;
          w_mem_wd_n   = w_pick_dsp ? '0 : bus.cpu_wd;
        end
      end
      ACCESS: begin
        if (r_owner == OWN_DSP) begin
          w_dsp_ack_n = 1'b1;
          w_dsp_err_n = r_oor;
          w_dsp_rd_n  = w_rd_cap;
        end else begin
          w_cpu_ack_n = 1'b1;
          w_cpu_err_n = r_oor;
          w_cpu_rd_n  = w_rd_cap;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= OWN_CPU;
      r_we       <= 1'b0;
      r_oor      <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_vec  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
      r_cpu_ack  <= 1'b0;
      r_cpu_err  <= 1'b0;
      r_cpu_rd   <= '0;
      r_dsp_ack  <= 1'b0;
      r_dsp_err  <= 1'b0;
      r_dsp_rd   <= '0;
    end else begin
      r_owner    <= w_owner_n;
      r_we       <= w_we_n;
      r_oor      <= w_oor_n;
      r_mem_we   <= w_mem_we_n;
      r_mem_vec  <= w_mem_vec_n;
      r_mem_addr <= w_mem_addr_n;
      r_mem_wd   <= w_mem_wd_n;
      r_cpu_ack  <= w_cpu_ack_n;
      r_cpu_err  <= w_cpu_err_n;
      r_cpu_rd   <= w_cpu_rd_n;
      r_dsp_ack  <= w_dsp_ack_n;
      r_dsp_err  <= w_dsp_err_n;
      r_dsp_rd   <= w_dsp_rd_n;
    end
  end

  assign bus.mem_we   = r_mem_we;
  assign bus.mem_vec  = r_mem_vec;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_wd   = r_mem_wd;
  assign bus.cpu_ack  = r_cpu_ack;
  assign bus.cpu_err  = r_cpu_err;
  assign bus.cpu_rd   = r_cpu_rd;
  assign bus.dsp_ack  = r_dsp_ack;
  assign bus.dsp_err  = r_dsp_err;
  assign bus.dsp_rd   = r_dsp_rd;

endmodule
